// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 serial receiver with 16x oversampling.
// Recovers bytes from rx and hands them over with a valid/ack handshake.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rx             asynchronous serial line, idle high
//   rd_ack         consumer read pulse, clears data_valid
//   err_clr        clears the sticky frame_err / overrun flags
//   data_out       last good byte
//   data_valid     data_out holds an unread byte
//   frame_err      sticky: a frame ended with a low stop bit
//   overrun        sticky: a byte replaced an unread byte
//   busy           receiver is inside a frame
module uart_rx_deser #(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;

    logic tick;
    logic start_edge;
    logic stop_done;
    logic load;
    logic ferr_set;

    assign tick       = (div_q == DIV_LAST);
    // Only a fresh 1->0 transition arms the receiver, so a held-low
    // line after a bad frame does not restart reception.
    assign start_edge = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == MID) begin
                        // Mid start bit: a high line here was a glitch.
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        stop_done = (state_q == STOP) && tick && (cnt_q == LAST);
        load      = stop_done & rx_s_q;
        ferr_set  = stop_done & ~rx_s_q;
        data_d    = load ? shift_q : data_q;
        // A new byte wins over a same-cycle read acknowledge.
        valid_d   = load | (valid_q & ~rd_ack);
        ovr_d     = (load & valid_q & ~rd_ack) | (ovr_q & ~err_clr);
        ferr_d    = ferr_set | (ferr_q & ~err_clr);
        busy_d    = (state_q != IDLE);
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed frames checked against a byte-level model.
// The model schedules each frame's outcome a fixed latency after its start edge.
module tb_uart_rx_deser;

    localparam int CLK_DIV = 4;
    localparam int OS      = 16;
    localparam int BIT     = CLK_DIV * OS;
    // 2 sync flops + 1 edge detect, then half a bit plus 9 full bits.
    localparam int LAT     = 3 + (OS / 2 + 9 * OS) * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_ack;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_deser #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_ack     (rd_ack),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Scheduled frame outcomes: cycle index, byte, stop bit good.
    int         ev_at   [16];
    logic [7:0] ev_byte [16];
    logic       ev_ok   [16];
    int         head = 0;
    int         tail = 0;
    int         cyc  = 0;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    logic due, m_load, m_fset;
    assign due    = (head != tail) && (ev_at[head[3:0]] == cyc);
    assign m_load = due && ev_ok[head[3:0]];
    assign m_fset = due && !ev_ok[head[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            head    <= tail;
        end else begin
            if (due) head <= head + 1;
            if (m_load) m_data <= ev_byte[head[3:0]];
            m_valid <= m_load | (m_valid & ~rd_ack);
            m_ovr   <= (m_load & m_valid & ~rd_ack) | (m_ovr & ~err_clr);
            m_ferr  <= m_fset | (m_ferr & ~err_clr);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        ev_at[tail[3:0]]   = cyc + LAT - 1;
        ev_byte[tail[3:0]] = b;
        ev_ok[tail[3:0]]   = stop;
        tail++;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            step(BIT);
        end
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int key;
        rst     = 1'b1;
        rx      = 1'b1;
        rd_ack  = 1'b0;
        err_clr = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (cmp_en) begin
                    n_chk++;
                    if ({data_out, data_valid, frame_err, overrun} !==
                        {m_data, m_valid, m_ferr, m_ovr}) begin
                        n_fail++;
                        $display("FAIL model cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                                 cyc, data_out, data_valid, frame_err, overrun,
                                 m_data, m_valid, m_ferr, m_ovr);
                    end
                end
            end
        join_none

        step(3);
        chk("rst data_out", 32'(data_out), 32'h00);
        chk("rst valid", 32'(data_valid), 0);
        chk("rst ferr", 32'(frame_err), 0);
        chk("rst ovr", 32'(overrun), 0);
        chk("rst busy", 32'(busy), 0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        step(5);

        // 1: plain frame, then read it
        send_frame(8'hA5, 1'b1);
        step(5);
        chk("t1 data", 32'(data_out), 32'hA5);
        chk("t1 valid", 32'(data_valid), 1);
        chk("t1 flags", 32'({frame_err, overrun}), 0);
        pulse_ack();
        chk("t1 ack", 32'(data_valid), 0);

        // 2: short low glitch aborts in START
        rx = 1'b0;
        step(8);
        rx = 1'b1;
        step(12);
        chk("t2 busy mid", 32'(busy), 1);
        step(60);
        chk("t2 busy end", 32'(busy), 0);
        chk("t2 valid", 32'(data_valid), 0);

        // 3: bad stop bit
        send_frame(8'h3C, 1'b0);
        step(5);
        chk("t3 ferr", 32'(frame_err), 1);
        chk("t3 valid", 32'(data_valid), 0);
        chk("t3 data", 32'(data_out), 32'hA5);
        pulse_clr();
        chk("t3 clr", 32'(frame_err), 0);

        // 4: back-to-back without read
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(5);
        chk("t4 ovr", 32'(overrun), 1);
        chk("t4 data", 32'(data_out), 32'h22);
        chk("t4 valid", 32'(data_valid), 1);

        // 5: rd_ack lands on the second frame's load cycle
        pulse_ack();
        pulse_clr();
        chk("t5 pre ovr", 32'(overrun), 0);
        chk("t5 pre valid", 32'(data_valid), 0);
        key = cyc + 10 * BIT + LAT - 1;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                while (cyc < key) step(1);
                rd_ack = 1'b1;
                step(1);
                rd_ack = 1'b0;
                chk("t5 load data", 32'(data_out), 32'h22);
                chk("t5 load valid", 32'(data_valid), 1);
            end
        join
        step(5);
        chk("t5 ovr", 32'(overrun), 0);
        chk("t5 data", 32'(data_out), 32'h22);

        // 6: reset in the middle of 0xFF, then a clean frame
        rx = 1'b0;
        step(BIT);
        rx = 1'b1;
        step(5 * BIT);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6 rst data", 32'(data_out), 32'h00);
        chk("t6 rst valid", 32'(data_valid), 0);
        chk("t6 rst busy", 32'(busy), 0);
        step(100);
        send_frame(8'h5A, 1'b1);
        step(5);
        chk("t6 data", 32'(data_out), 32'h5A);
        chk("t6 valid", 32'(data_valid), 1);
        chk("t6 flags", 32'({frame_err, overrun}), 0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
